// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank shared types
// response codes and write-channel states
package axi_lite_regbank_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_HELD,
    DATA_HELD,
    RESP
  } wstate_t;

endpackage

// File: rtl/axi_lite_regbank_if.sv
// axi_lite_regbank AXI4-Lite bus bundle
// master drives requests, slave drives responses
interface axi_lite_regbank_if #(
  parameter int DW = 32,
  parameter int AW = 8
);

  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axi_lite_regbank_wchan.sv
// axi_lite_regbank write channel
// AW/W capture, commit decision, B response
module axi_lite_regbank_wchan
  import axi_lite_regbank_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int NREGS = 8,
  parameter logic [NREGS-1:0] RO_MASK = '0,
  localparam int LSB = $clog2(DW/8),
  localparam int IW = AW - LSB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_rdy_en,
  input  logic [AW-1:0]   i_awaddr,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic            i_wvalid,
  output logic            o_wready,
  output logic [1:0]      o_bresp,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic            o_we,
  output logic [IW-1:0]   o_widx,
  output logic [DW-1:0]   o_wdata,
  output logic [DW/8-1:0] o_wstrb
);

  wstate_t         r_state;
  wstate_t         w_next;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_data;
  logic [DW/8-1:0] r_strb;
  logic [1:0]      r_bresp;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_commit;
  logic          w_hit;
  logic          w_ro;
  logic          w_ok;
  logic [IW-1:0] w_aidx;
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_aidx = i_awaddr[AW-1:LSB];
  assign w_unused = &{1'b0, i_awaddr[LSB-1:0]};

  assign o_awready = i_rdy_en &
    (r_state == IDLE || r_state == DATA_HELD);
  assign o_wready = i_rdy_en &
    (r_state == IDLE || r_state == ADDR_HELD);

  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid & o_wready;

  // a same-cycle handshake bypasses the holding registers
  assign w_idx = (r_state == ADDR_HELD) ? r_idx : w_aidx;
  assign o_wdata = (r_state == DATA_HELD) ? r_data : i_wdata;
  assign o_wstrb = (r_state == DATA_HELD) ? r_strb : i_wstrb;
  assign o_widx = w_idx;

  always_comb begin
    w_hit = 1'b0;
    w_ro  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_idx == IW'(i)) begin
        w_hit = 1'b1;
        w_ro  = RO_MASK[i];
      end
    end
  end

  assign w_ok = w_hit & ~w_ro;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end else if (w_aw_hs) begin
          w_next = ADDR_HELD;
        end else if (w_w_hs) begin
          w_next = DATA_HELD;
        end
      end
      ADDR_HELD: begin
        if (w_w_hs) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      DATA_HELD: begin
        if (w_aw_hs) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        if (i_bready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_bresp <= OKAY;
    end else begin
      if (w_aw_hs) r_idx <= w_aidx;
      if (w_w_hs) begin
        r_data <= i_wdata;
        r_strb <= i_wstrb;
      end
      if (w_commit) r_bresp <= w_ok ? OKAY : SLVERR;
    end
  end

  assign o_we     = w_commit & w_ok;
  assign o_bvalid = (r_state == RESP);
  assign o_bresp  = r_bresp;

endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank top
// register array, read path, write channel glue
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = 8'hC0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  axi_lite_regbank_if.slave s_axi,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0] wr_pulse
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int NR  = C_NUM_REGS;
  localparam int LSB = $clog2(DW/8);
  localparam int IW  = AW - LSB;

  logic            r_rdy_en;
  logic [DW-1:0]   r_regs [NR];
  logic [NR-1:0]   r_wr_pulse;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_rresp;

  logic            w_we;
  logic [IW-1:0]   w_widx;
  logic [DW-1:0]   w_wdata;
  logic [DW/8-1:0] w_wstrb;
  logic            w_ar_hs;
  logic [IW-1:0]   w_ridx;
  logic            w_rhit;
  logic [DW-1:0]   w_rval;
  logic            w_unused;

  assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT,
    s_axi.S_AXI_ARPROT,
    s_axi.S_AXI_ARADDR[LSB-1:0], reg_in};

  // readies stay low until the first edge out of reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rdy_en <= 1'b0;
    else                r_rdy_en <= 1'b1;
  end

  axi_lite_regbank_wchan #(
    .DW      (DW),
    .AW      (AW),
    .NREGS   (NR),
    .RO_MASK (C_RO_MASK)
  ) u_wchan (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .i_rdy_en  (r_rdy_en),
    .i_awaddr  (s_axi.S_AXI_AWADDR),
    .i_awvalid (s_axi.S_AXI_AWVALID),
    .o_awready (s_axi.S_AXI_AWREADY),
    .i_wdata   (s_axi.S_AXI_WDATA),
    .i_wstrb   (s_axi.S_AXI_WSTRB),
    .i_wvalid  (s_axi.S_AXI_WVALID),
    .o_wready  (s_axi.S_AXI_WREADY),
    .o_bresp   (s_axi.S_AXI_BRESP),
    .o_bvalid  (s_axi.S_AXI_BVALID),
    .i_bready  (s_axi.S_AXI_BREADY),
    .o_we      (w_we),
    .o_widx    (w_widx),
    .o_wdata   (w_wdata),
    .o_wstrb   (w_wstrb)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int i = 0; i < NR; i++) begin
        if (w_we && !C_RO_MASK[i] && w_widx == IW'(i)) begin
          r_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < DW/8; b++) begin
            if (w_wstrb[b])
              r_regs[i][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NR; i++) reg_out[i*DW +: DW] = r_regs[i];
  end

  assign wr_pulse = r_wr_pulse;

  assign s_axi.S_AXI_ARREADY = r_rdy_en & ~r_rvalid;
  assign w_ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign w_ridx  = s_axi.S_AXI_ARADDR[AW-1:LSB];

  always_comb begin
    w_rhit = 1'b0;
    w_rval = '0;
    for (int i = 0; i < NR; i++) begin
      if (w_ridx == IW'(i)) begin
        w_rhit = 1'b1;
        w_rval = C_RO_MASK[i] ? reg_in[i*DW +: DW] : r_regs[i];
      end
    end
  end

  // r_regs is sampled before any same-edge write lands
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rhit ? w_rval : '0;
      r_rresp  <= w_rhit ? OKAY : SLVERR;
    end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi.S_AXI_RVALID = r_rvalid;
  assign s_axi.S_AXI_RDATA  = r_rdata;
  assign s_axi.S_AXI_RRESP  = r_rresp;

endmodule
